// File: rtl/load_extend_sequencer.sv
// Load sequencer: word-aligned memory read, lane shift, then extend and capture.
// Optional MISALIGN_TRAP_EN turns misaligned half/word loads into faults.
module load_extend_sequencer #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  loadType,
  input  logic [31:0] address,
  output logic        busy,
  output logic        done,
  output logic        fault,
  output logic [31:0] loadData,
  output logic        memRead,
  output logic [31:0] memAddress,
  input  logic        memReady,
  input  logic [31:0] memData,
  output logic [2:0]  extendControl,
  output logic [31:0] extendInput,
  input  logic [31:0] extendOutput
);

  // state  | meaning
  // IDLE   | waiting for start
  // ACCESS | memRead held, waiting on memReady or timeout
  // ALIGN  | extendControl driven, extend unit settling
  // DONE   | loadData captured, done pulse
  // FAULT  | done + fault pulse, loadData untouched
  typedef enum logic [2:0] {IDLE, ACCESS, ALIGN, DONE, FAULT} state_t;

  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic TIMEOUT_EN = (TIMEOUT_CYCLES != 0);

  state_t          state, state_next;
  logic [2:0]      lat_type;
  logic [1:0]      addr_lo;
  logic [TW-1:0]   timer;
  logic [31:0]     lane_data;
  logic            illegal, misaligned;

  assign illegal = (loadType > 3'd4);

`ifdef MISALIGN_TRAP_EN
  assign misaligned = (((loadType == 3'd1) || (loadType == 3'd3)) && address[0]) ||
                      ((loadType == 3'd0) && (address[1:0] != 2'b00));
`else
  assign misaligned = 1'b0;
`endif

  always_comb begin
    lane_data = '0;
    case (lat_type)
      3'd0:       lane_data = memData;
      3'd1, 3'd3: lane_data[15:0] = addr_lo[1] ? memData[31:16] : memData[15:0];
      3'd2, 3'd4: lane_data[7:0] = memData[{addr_lo, 3'b000} +: 8];
      default:    lane_data = '0;
    endcase
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (start) state_next = (illegal || misaligned) ? FAULT : ACCESS;
      end
      ACCESS: begin
        if (memReady)                              state_next = ALIGN;
        else if (TIMEOUT_EN && (timer == TW'(1)))  state_next = FAULT;
      end
      ALIGN:   state_next = DONE;
      DONE:    state_next = IDLE;
      FAULT:   state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      lat_type    <= '0;
      addr_lo     <= '0;
      timer       <= '0;
      memAddress  <= '0;
      extendInput <= '0;
      loadData    <= '0;
    end else begin
      state <= state_next;
      if (state == IDLE && start) begin
        lat_type   <= loadType;
        addr_lo    <= address[1:0];
        memAddress <= {address[31:2], 2'b00};
        timer      <= TW'(TIMEOUT_CYCLES);
      end
      if (state == ACCESS) begin
        if (memReady) extendInput <= lane_data;
        else          timer       <= timer - TW'(1);
      end
      // extend unit has had the whole ALIGN cycle to settle
      if (state == ALIGN) loadData <= extendOutput;
    end
  end

  always_comb begin
    busy          = (state != IDLE);
    done          = (state == DONE) || (state == FAULT);
    fault         = (state == FAULT);
    memRead       = (state == ACCESS);
    extendControl = ((state == ALIGN) || (state == DONE)) ? lat_type : 3'd0;
  end

endmodule

// File: tb/tb_load_extend_sequencer.sv
// Bench for load_extend_sequencer: directed plan cases plus random loads vs. a
// behavioural load model; includes a simple extend-unit model as environment.
module tb_load_extend_sequencer;
  localparam int TMO = 8;

  logic        clock, reset, start;
  logic [2:0]  loadType;
  logic [31:0] address;
  logic        busy, done, fault, memRead, memReady;
  logic [31:0] loadData, memAddress, memData, extendInput, extendOutput;
  logic [2:0]  extendControl;

  int total = 0;
  int bad = 0;
  logic [31:0] prev_load = 32'h0;

  load_extend_sequencer #(.TIMEOUT_CYCLES(TMO)) dut (
    .clock(clock), .reset(reset), .start(start), .loadType(loadType),
    .address(address), .busy(busy), .done(done), .fault(fault),
    .loadData(loadData), .memRead(memRead), .memAddress(memAddress),
    .memReady(memReady), .memData(memData), .extendControl(extendControl),
    .extendInput(extendInput), .extendOutput(extendOutput)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // extend unit stand-in
  always_comb begin
    extendOutput = 32'h0;
    case (extendControl)
      3'd0: extendOutput = extendInput;
      3'd1: extendOutput = {{16{extendInput[15]}}, extendInput[15:0]};
      3'd2: extendOutput = {{24{extendInput[7]}}, extendInput[7:0]};
      3'd3: extendOutput = {16'h0, extendInput[15:0]};
      3'd4: extendOutput = {24'h0, extendInput[7:0]};
      default: extendOutput = 32'h0;
    endcase
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model_load(input logic [2:0] t, input logic [31:0] a,
                                             input logic [31:0] d);
    logic [15:0] h;
    logic [7:0]  b;
    h = 16'(d >> (16 * a[1]));
    b = 8'(d >> (8 * a[1:0]));
    case (t)
      3'd0: return d;
      3'd1: return 32'($signed(h));
      3'd2: return 32'($signed(b));
      3'd3: return {16'h0, h};
      default: return {24'h0, b};
    endcase
  endfunction

  function automatic bit model_fault_now(input logic [2:0] t, input logic [31:0] a);
    bit f;
    f = (t > 3'd4);
`ifdef MISALIGN_TRAP_EN
    if ((t == 3'd1 || t == 3'd3) && a[0]) f = 1'b1;
    if (t == 3'd0 && a[1:0] != 2'b00) f = 1'b1;
`endif
    return f;
  endfunction

  // one load; w = memReady-low cycles before memReady goes high
  task automatic run_load(input logic [2:0] t, input logic [31:0] a,
                          input logic [31:0] d, input int w);
    int n, reads;
    @(negedge clock);
    start = 1'b1; loadType = t; address = a; memData = d; memReady = 1'b0;
    @(negedge clock);
    start = 1'b0; loadType = 3'($urandom); address = $urandom;
    n = 1; reads = 0;
    if (model_fault_now(t, a)) begin
      check("acc_fault_done", {31'h0, done}, 32'h1);
      check("acc_fault_fault", {31'h0, fault}, 32'h1);
      check("acc_fault_memread", {31'h0, memRead}, 32'h0);
      check("acc_fault_loaddata", loadData, prev_load);
      @(negedge clock);
      check("acc_fault_idle", {30'h0, busy, done}, 32'h0);
      return;
    end
    for (int i = 0; i <= w && i < TMO; i++) begin
      if (memRead) reads++;
      if (i == 0) check("mem_address", memAddress, {a[31:2], 2'b00});
      memReady = (i == w);
      @(negedge clock);
      memReady = 1'($urandom);
      n++;
    end
    if (w >= TMO) begin
      check("tmo_reads", reads, TMO);
      check("tmo_done_fault", {30'h0, done, fault}, 32'h3);
      check("tmo_memread", {31'h0, memRead}, 32'h0);
      check("tmo_loaddata", loadData, prev_load);
    end else begin
      check("reads", reads, w + 1);
      check("align_memread", {31'h0, memRead}, 32'h0);
      check("align_ctrl", {29'h0, extendControl}, {29'h0, t});
      check("align_done", {31'h0, done}, 32'h0);
      start = 1'b1;  // must be ignored while busy
      @(negedge clock);
      start = 1'b0;
      n++;
      check("done_pulse", {30'h0, done, fault}, 32'h2);
      check("latency", n, w + 3);
      check("loaddata", loadData, model_load(t, a, d));
      prev_load = model_load(t, a, d);
    end
    @(negedge clock);
    memReady = 1'b0;
    check("idle_after", {28'h0, busy, done, extendControl != 3'd0, memRead}, 32'h0);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; loadType = 3'd0; address = 32'h0;
    memReady = 1'b0; memData = 32'h0;
    repeat (2) @(negedge clock);
    check("rst_outs", {27'h0, busy, done, fault, memRead, 1'b0}, 32'h0);
    check("rst_loaddata", loadData, 32'h0);
    check("rst_memaddr", memAddress, 32'h0);
    check("rst_extin", extendInput, 32'h0);
    check("rst_extctl", {29'h0, extendControl}, 32'h0);
    reset = 1'b0;

    run_load(3'd2, 32'h0000_1003, 32'h80F1_7F82, 0);
    run_load(3'd3, 32'h0000_2002, 32'h80F1_7F82, 0);
    run_load(3'd1, 32'h0000_2002, 32'h80F1_7F82, 0);
    run_load(3'd4, 32'h0000_2000, 32'h80F1_7F82, 0);
    run_load(3'd0, 32'h0000_3000, 32'h80F1_7F82, 4);
    run_load(3'd1, 32'h0000_2001, 32'h80F1_7F82, 0);
    run_load(3'd0, 32'h0000_4000, 32'h1234_5678, TMO);
    run_load(3'd6, 32'h0000_5000, 32'h1234_5678, 0);
    run_load(3'd0, 32'h0000_3002, 32'hCAFE_F00D, 1);

    // reset in the middle of ACCESS
    @(negedge clock);
    start = 1'b1; loadType = 3'd0; address = 32'h6000; memReady = 1'b0;
    @(negedge clock);
    start = 1'b0;
    @(negedge clock);
    check("pre_rst_memread", {31'h0, memRead}, 32'h1);
    #2 reset = 1'b1;
    #1;
    check("async_rst", {29'h0, busy, memRead, done}, 32'h0);
    check("async_rst_loaddata", loadData, 32'h0);
    prev_load = 32'h0;
    @(negedge clock);
    reset = 1'b0;
    run_load(3'd2, 32'h0000_7001, 32'h0000_8000, 2);

    for (int k = 0; k < 40; k++) begin
      logic [2:0] t;
      int w;
      t = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(5, 7)) : 3'($urandom_range(0, 4));
      w = ($urandom_range(0, 9) == 0) ? TMO + 1 : int'($urandom_range(0, TMO - 1));
      run_load(t, $urandom, $urandom, w);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
